// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART transmit path among NUM_REQ requesters.
// Optional watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic                 tx_done,
    output logic                 trmt,
    output logic [7:0]           resp,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy,
    output logic [2:0]           gnt_id,
    output logic                 err
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    state_t state, state_n;
    logic [2:0] last, pick;
    logic found, tx_done_q, done_edge, to_hit;
    logic [NUM_REQ-1:0] sh;
    int idx;
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_cfg_err
        $error("uart_tx_arb: unsupported parameter values");
    end
    // search starts one past the previous winner and wraps
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        sh    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            sh  = req >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                pick  = 3'(idx);
            end
        end
    end
    assign done_edge = tx_done & ~tx_done_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [31:0] wd;
    logic err_q;
    assign to_hit = state == BUSY && wd == 32'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            wd    <= state == BUSY ? wd + 32'd1 : '0;
            err_q <= to_hit && !done_edge;
        end
    end
    assign err = err_q;
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (found ? BUSY : IDLE) :
                  state == BUSY ? ((done_edge || to_hit) ? ACK : BUSY) : IDLE;
    end
    assign busy = state != IDLE;
    assign ack  = state == ACK ? NUM_REQ'(1) << gnt_id : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            trmt      <= 1'b0;
            resp      <= 8'h00;
            gnt_id    <= '0;
            last      <= 3'(NUM_REQ - 1);
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= tx_done;
            trmt      <= state == IDLE && found;
            if (state == IDLE && found) begin
                gnt_id <= pick;
                last   <= pick;
                resp   <= 8'(req_data >> (8 * int'(pick)));
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb (NUM_REQ=3, TIMEOUT_CYC=16).
module tb_uart_tx_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] req = '0;
    logic [23:0] req_data = '0;
    logic tx_done = 1'b0;
    logic trmt, busy, err;
    logic [7:0] resp;
    logic [2:0] ack, gnt_id;
    int checks = 0;
    int failures = 0;
    int trmt_cnt = 0;
    logic trmt_prev = 1'b0;
    typedef struct {logic [2:0] id; logic [7:0] b; logic e;} exp_t;
    exp_t sb[$];

    uart_tx_arb #(.NUM_REQ(3), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .tx_done(tx_done),
        .trmt(trmt), .resp(resp), .ack(ack), .busy(busy), .gnt_id(gnt_id), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (trmt) begin
                trmt_cnt++;
                check("trmt_width", {31'd0, trmt_prev}, 0);
                if (sb.size() == 0) check("trmt_unexp", 1, 0);
                else begin
                    check("resp", {24'd0, resp}, {24'd0, sb[0].b});
                    check("gnt_id", {29'd0, gnt_id}, {29'd0, sb[0].id});
                end
            end
            if (ack != 0) begin
                if (sb.size() == 0) check("ack_unexp", {29'd0, ack}, 0);
                else begin
                    check("ack", {29'd0, ack}, {29'd0, 3'b001 << sb[0].id});
                    check("err", {31'd0, err}, {31'd0, sb[0].e});
                    void'(sb.pop_front());
                end
            end else if (err) check("err_stray", {31'd0, err}, 0);
        end
        trmt_prev = trmt;
    end

    task automatic set_req(input int id, input logic [7:0] b, input logic e);
        req_data[8*id +: 8] = b;
        req[id] = 1'b1;
        sb.push_back('{3'(id), b, e});
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_trmt;
        bit seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            seen = trmt;
        end
        if (!seen) check("trmt_timeout", 0, 1);
    endtask

    task automatic wait_ack;
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = ack != 0;
        end
        if (!seen) check("ack_timeout", 0, 1);
    endtask

    task automatic finish(input int id, input bit drop_done);
        repeat (2) @(negedge clk);
        tx_done = 1'b1;
        wait_ack;
        req[id] = 1'b0;
        if (drop_done) tx_done = 1'b0;
        @(negedge clk);
        check("busy_after_ack", {31'd0, busy}, 0);
    endtask

    initial begin
        do_reset;
        @(negedge clk);
        check("rst_trmt", {31'd0, trmt}, 0);
        check("rst_resp", {24'd0, resp}, 0);
        check("rst_ack", {29'd0, ack}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_gnt", {29'd0, gnt_id}, 0);
        check("rst_err", {31'd0, err}, 0);
        // single byte from requester 0
        set_req(0, 8'hA5, 1'b0);
        @(negedge clk);
        check("t1_trmt", {31'd0, trmt}, 1);
        check("t1_busy", {31'd0, busy}, 1);
        @(negedge clk);
        check("t1_trmt_fall", {31'd0, trmt}, 0);
        finish(0, 1);
        // three simultaneous requesters, fresh pointer
        do_reset;
        trmt_cnt = 0;
        set_req(0, 8'h11, 1'b0);
        set_req(1, 8'h22, 1'b0);
        set_req(2, 8'h33, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_trmt;
            finish(i, 1);
        end
        repeat (4) @(negedge clk);
        check("t2_trmt_cnt", trmt_cnt, 3);
        // stale-high tx_done must not complete the next byte
        set_req(0, 8'h5A, 1'b0);
        wait_trmt;
        finish(0, 0);
        set_req(1, 8'h6B, 1'b0);
        wait_trmt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t3_no_ack", {29'd0, ack}, 0);
        end
        tx_done = 1'b0;
        finish(1, 1);
        // request withdrawn and data changed mid-transfer
        set_req(1, 8'h3C, 1'b0);
        wait_trmt;
        @(negedge clk);
        req[1] = 1'b0;
        req_data[15:8] = 8'hFF;
        repeat (3) @(negedge clk);
        check("t4_resp_hold", {24'd0, resp}, 32'h3C);
        finish(1, 1);
        // reset in the middle of a transfer
        set_req(2, 8'h77, 1'b0);
        wait_trmt;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_trmt", {31'd0, trmt}, 0);
        check("t5_resp", {24'd0, resp}, 0);
        check("t5_ack", {29'd0, ack}, 0);
        check("t5_busy", {31'd0, busy}, 0);
        check("t5_gnt", {29'd0, gnt_id}, 0);
        sb.delete();
        req = '0;
        rst = 1'b0;
        @(negedge clk);
        set_req(0, 8'h81, 1'b0);
        set_req(2, 8'h82, 1'b0);
        wait_trmt;
        finish(0, 1);
        wait_trmt;
        finish(2, 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
        begin
            int lat = 0;
            bit seen = 1'b0;
            set_req(0, 8'hC3, 1'b1);
            wait_trmt;
            for (int n = 1; n <= 40 && !seen; n++) begin
                @(negedge clk);
                if (ack != 0) begin
                    seen = 1'b1;
                    lat = n;
                end
            end
            check("t6_latency", lat, 16);
            req[0] = 1'b0;
            repeat (4) @(negedge clk);
            check("t6_busy", {31'd0, busy}, 0);
        end
`endif
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares the single UART transmit path (the `trmt` / `resp` / `tx_done` side of the UART wrapper) among several on-chip requesters. Typical requesters are the command-processor acknowledge, the tour-complete notifier and the fault reporter. It sits between those requesters and the UART wrapper. It latches one requester's byte, issues a single-cycle `trmt`, waits for the transmitter to report completion, then acknowledges that requester. Only one byte is ever in flight.

## Interface
- `NUM_REQ`, default 3: number of requesters (2..8).
- `TIMEOUT_CYC`, default 65536: watchdog limit in clocks. Used only when `UART_TX_ARB_TIMEOUT_EN` is defined.
- `clk` input, 1 bit: single system clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `req` input, `NUM_REQ` bits: per-requester transmit request (level). The requester holds it high until it sees its `ack` bit.
- `req_data` input, `NUM_REQ*8` bits: byte `i` occupies bits [8i+7:8i]. It must be stable while `req[i]` is high.
- `tx_done` input, 1 bit: from the UART wrapper; level, rises when the byte has finished shifting out.
- `trmt` output, 1 bit: to the UART wrapper; one-cycle start pulse.
- `resp` output, 8 bits: to the UART wrapper; the byte being transmitted.
- `ack` output, `NUM_REQ` bits: one-hot, one-cycle completion pulse to the granted requester.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `gnt_id` output, 3 bits: index of the current or most recent grant.
- `err` output, 1 bit: one-cycle timeout flag; tied 0 when the watchdog is compiled out.

## Operation
- States and transitions:
  - IDLE → BUSY when any `req` bit is high.
  - BUSY → ACK when a rising edge of `tx_done` is detected, or on watchdog expiry.
  - ACK → IDLE unconditionally.
- Round-robin pointer `last`:
  - Reset value is `NUM_REQ-1`, so requester 0 wins the first grant.
  - The search starts at `last+1` and wraps modulo `NUM_REQ`; the first `req` bit found high is granted.
  - `last` is updated to the granted index when the grant is made in IDLE.
- Grant in IDLE at cycle t: register `gnt_id`, load `resp` from the granted `req_data` slice, and register `trmt`=1.
- The byte is latched at grant; later changes to `req_data` or `req` are ignored until the next grant.
- `tx_done` is registered as `tx_done_q`. Completion is the condition `tx_done & ~tx_done_q` while in BUSY. This ignores a stale-high `tx_done` left over from the previous byte.
- `req` is not sampled in BUSY or ACK. Deasserting a granted `req` mid-transfer does not abort the transfer; `ack` is still pulsed.
- ACK state: `ack[gnt_id]`=1 for exactly that cycle. The requester drops `req` on seeing it, so IDLE in the following cycle no longer sees the request.
- Reset values: `trmt`=0, `resp`=8'h00, `ack`=0, `busy`=0, `gnt_id`=0, `err`=0, state IDLE, `tx_done_q`=0, `last`=`NUM_REQ-1`, watchdog count=0.
- Reset asserted mid-transfer: all outputs return to reset values on that edge and no `ack` is issued. A byte already shifting in the UART is not recalled. The requester must re-request after reset.

## Timing
- Cycle t: IDLE with `req` high.
- Cycle t+1: `trmt`=1, `resp` valid, `busy`=1.
- Cycle t+2: `trmt`=0.
- `resp` holds its value until the next grant.
- Completion edge seen at cycle c: ACK occupies cycle c+1 with `ack` high. IDLE is at c+2, and the earliest next `trmt` is at c+3.
- Minimum spacing between `trmt` pulses is therefore 3 cycles plus the UART frame time.
- When several `req` bits are simultaneous, exactly one grant is made per IDLE visit. No requester waits more than `NUM_REQ-1` other transfers.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches `TIMEOUT_CYC-1` with no completion edge, the block moves to ACK anyway and asserts `err` together with `ack` for that single cycle.
  - If completion and timeout occur in the same cycle, completion wins and `err`=0.
- Not defined: no counter is present, `err` is constant 0, and BUSY waits indefinitely for `tx_done`.

## Test plan
- Reset, then `req`=3'b001 with byte 0 = 8'hA5 → `trmt` pulse at t+1 with `resp`=8'hA5; after the `tx_done` rise, `ack`=3'b001 for one cycle; `busy` low 2 cycles after the edge.
- `req`=3'b111 held, bytes 8'h11/8'h22/8'h33, each requester dropping its `req` on its `ack` → transmit order 8'h11, 8'h22, 8'h33; exactly 3 `trmt` pulses.
- `tx_done` held high from the previous byte when a new grant occurs → no premature `ack`; `ack` only after `tx_done` falls and then rises again.
- `req[1]` deasserted and `req_data` changed to 8'hFF during BUSY → UART still receives the originally latched byte; `ack[1]` still pulses.
- `rst` asserted 5 cycles into BUSY → next cycle `trmt`=0, `resp`=8'h00, `ack`=0, `busy`=0; after release, requester 0 wins first.
- With `UART_TX_ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=16, `tx_done` stuck low → `ack` and `err` both high in the same single cycle, 16 cycles after BUSY entry; `err`=0 in all other cycles.
